// File: rtl/mem_port_arbiter.sv
// Single-ported unified memory sequencer shared by fetch (I-side) and the memory stage (D-side).
// D-side wins by default; a fairness counter forces an I grant after FAIR_MAX D grants in a row.
module mem_port_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MEM_LAT  = 2,
  parameter int unsigned FAIR_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            IReq,
  input  logic [XLEN-1:0] IAddr,
  input  logic            FlushI,
  output logic            IAck,
  output logic [XLEN-1:0] IRData,
  input  logic            DReq,
  input  logic            DWe,
  input  logic [XLEN-1:0] DAddr,
  input  logic [XLEN-1:0] DWData,
  output logic            DAck,
  output logic [XLEN-1:0] DRData,
  output logic            MemEn,
  output logic            MemWe,
  output logic [XLEN-1:0] MemAddr,
  output logic [XLEN-1:0] MemWData,
  input  logic [XLEN-1:0] MemRData,
  output logic            StallF,
  output logic            StallM,
  output logic            Busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusyD = 2'd1;
  localparam logic [1:0] StBusyI = 2'd2;

  localparam logic [3:0] LatLoad = 4'(MEM_LAT - 1);
  localparam logic [3:0] FairMax = 4'(FAIR_MAX);

  logic [1:0]      stateQ, stateD;
  logic [3:0]      latCntQ, latCntD;
  logic [3:0]      fairCntQ, fairCntD;
  logic            discardQ, discardD;
  logic            iAckQ, iAckD;
  logic            dAckQ, dAckD;
  logic [XLEN-1:0] iRDataQ, iRDataD;
  logic [XLEN-1:0] dRDataQ, dRDataD;
  logic [XLEN-1:0] addrQ, addrD;
  logic [XLEN-1:0] wDataQ, wDataD;

  logic isIdle, lastCycle;
  logic dReqEff, iReqEff, fairHit;
  logic grantD, grantI;

  // A requester being acked this cycle is still holding Req; mask it to avoid a duplicate grant.
  assign dReqEff   = DReq & ~dAckQ;
  assign iReqEff   = IReq & ~iAckQ;
  assign fairHit   = iReqEff & (fairCntQ == FairMax);
  assign isIdle    = (stateQ == StIdle);
  assign lastCycle = ~isIdle & (latCntQ == 4'd0);

  assign grantD = isIdle & ~reset & dReqEff & ~fairHit;
  assign grantI = isIdle & ~reset & ~grantD & iReqEff & ~FlushI;

  always_comb begin
    stateD   = stateQ;
    latCntD  = latCntQ;
    discardD = discardQ;
    case (stateQ)
      StIdle: begin
        discardD = 1'b0;
        if (grantD) begin
          stateD  = StBusyD;
          latCntD = LatLoad;
        end else if (grantI) begin
          stateD  = StBusyI;
          latCntD = LatLoad;
        end
      end
      StBusyD, StBusyI: begin
        if ((stateQ == StBusyI) && FlushI) begin
          discardD = 1'b1;
        end
        if (lastCycle) begin
          stateD   = StIdle;
          discardD = 1'b0;
        end else begin
          latCntD = latCntQ - 4'd1;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    fairCntD = fairCntQ;
    if (!IReq || grantI) begin
      fairCntD = 4'd0;
    end else if (grantD && (fairCntQ != FairMax)) begin
      fairCntD = fairCntQ + 4'd1;
    end
  end

  // A flush landing in the completion cycle still suppresses the fetch ack.
  always_comb begin
    dAckD   = (stateQ == StBusyD) & lastCycle;
    iAckD   = (stateQ == StBusyI) & lastCycle & ~discardQ & ~FlushI;
    iRDataD = iAckD ? MemRData : iRDataQ;
    dRDataD = dAckD ? MemRData : dRDataQ;
  end

  always_comb begin
    addrD  = addrQ;
    wDataD = wDataQ;
    if (grantD) begin
      addrD  = DAddr;
      wDataD = DWData;
    end else if (grantI) begin
      addrD  = IAddr;
      wDataD = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      latCntQ  <= 4'd0;
      fairCntQ <= 4'd0;
      discardQ <= 1'b0;
      iAckQ    <= 1'b0;
      dAckQ    <= 1'b0;
      iRDataQ  <= '0;
      dRDataQ  <= '0;
      addrQ    <= '0;
      wDataQ   <= '0;
    end else begin
      stateQ   <= stateD;
      latCntQ  <= latCntD;
      fairCntQ <= fairCntD;
      discardQ <= discardD;
      iAckQ    <= iAckD;
      dAckQ    <= dAckD;
      iRDataQ  <= iRDataD;
      dRDataQ  <= dRDataD;
      addrQ    <= addrD;
      wDataQ   <= wDataD;
    end
  end

  // The issue cycle drives the bus straight from the winner; busy cycles hold the latched copy.
  always_comb begin
    MemEn    = grantD | grantI;
    MemWe    = grantD & DWe;
    MemAddr  = '0;
    MemWData = '0;
    if (grantD) begin
      MemAddr  = DAddr;
      MemWData = DWData;
    end else if (grantI) begin
      MemAddr = IAddr;
    end else if (!isIdle) begin
      MemAddr  = addrQ;
      MemWData = wDataQ;
    end
  end

  assign IAck   = iAckQ;
  assign DAck   = dAckQ;
  assign IRData = iRDataQ;
  assign DRData = dRDataQ;
  assign StallF = IReq & ~iAckQ & ~FlushI;
  assign StallM = DReq & ~dAckQ;
  assign Busy   = ~isIdle;

endmodule
